proccessing_element: RTL and testbench
======================================

PROCCESSING_ELEMENT -- requirements
Module: proccessing_element

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 r  input  8  unsigned reference-block pixel.
REQ-004 s1  input  8  unsigned search-area pixel, stream 1.
REQ-005 s2  input  8  unsigned search-area pixel, stream 2.
REQ-006 s1s2_mux  input  1  search-pixel select: 1 selects s1, 0 selects s2.
REQ-007 new_dist  input  1  1 starts a new distortion sum; 0 adds to the running sum.
REQ-008 accumulate  output  8  registered running sum of absolute differences (SAD).
REQ-009 r_pipe  output  8  r delayed by one clock, for daisy-chaining the next element.

Function
REQ-010 Selected pixel: s = s1 when s1s2_mux=1, else s2; purely combinational.
REQ-011 Absolute difference: d = |r - s|; unsigned 8-bit result in the range 0..255; r=s gives d=0.
REQ-012 Computation: d uses a 9-bit subtraction; when the borrow is set, the result is negated.
REQ-013 Accumulator update on each rising clock edge:
- new_dist=1: accumulate <= d, discarding the previous sum.
- new_dist=0: accumulate <= accumulate + d, with overflow handled per REQ-019/REQ-020.
REQ-014 Pipeline: r_pipe <= r on each rising clock edge.
REQ-015 Latency: accumulate and r_pipe reflect inputs sampled at edge N immediately after edge N (one cycle); there is no combinational input-to-output path.
REQ-016 Enables: none; both registers update every cycle and inputs are sampled only at the rising edge.
REQ-017 Unknown values: an X on s1s2_mux or new_dist is a bench error; the design does not need to define behaviour for it.

Reset
REQ-018 Reset value: while reset_n=0, accumulate=8'h00 and r_pipe=8'h00, asynchronously and without waiting for a clock edge.
- After reset_n is released, the first rising edge performs a normal update per REQ-013/REQ-014.
- An assertion of reset_n mid-sum discards the sum.
- When reset_n deasserts, the first edge with new_dist=0 accumulates onto 0.

Configuration
REQ-019 With macro PE_SATURATE_EN defined, an accumulate + d sum exceeding 255 clamps to 8'hFF.
- Once at 8'hFF, accumulate stays there until new_dist=1 or reset.
REQ-020 With PE_SATURATE_EN undefined, accumulate + d wraps modulo 256 (the carry is discarded).
REQ-021 The macro changes no ports and no timing; only the overflow rule differs.

Verification
REQ-022 Reset and pipe:
- Assert reset_n=0 mid-run -> accumulate=0 and r_pipe=0 immediately.
- Release, drive r=8'h2A -> r_pipe=8'h2A one edge later.
REQ-023 Start and accumulate, one row per rising edge, with the expected value after that edge:

| Edge | r | s1 | s2 | s1s2_mux | new_dist | accumulate |
|---|---|---|---|---|---|---|
| 1 | 8 | 0 | 8 | 1 | 1 | 8 |
| 2 | 0 | 1 | – | 1 | 0 | 9 |
| 3 | 1 | – | 5 | 0 | 0 | 13 |
| 4 | 2 | – | 7 | 0 | 0 | 18 |

REQ-024 Mux select: r=2, s1=0, s2=7, new_dist=1:
- s1s2_mux=1 -> accumulate=2.
- s1s2_mux=0 -> accumulate=5.
REQ-025 Overflow: accumulate=13, then r=5, s1=255, s1s2_mux=1, new_dist=0 (d=250):
- PE_SATURATE_EN defined -> 255.
- PE_SATURATE_EN undefined -> 7.
REQ-026 Restart: new_dist=1 with r=s -> accumulate=0 regardless of the prior sum, including from 8'hFF.

Source files
------------

// File: rtl/proccessing_element.sv
// Absolute-difference accumulator for block-matching motion estimation, with a one-cycle r pipe for chaining.
// Optional macro PE_SATURATE_EN: clamp accumulate at 8'hFF instead of wrapping modulo 256.
module proccessing_element (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] r,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic       s1s2_mux,
  input  logic       new_dist,
  output logic [7:0] accumulate,
  output logic [7:0] r_pipe
);

  logic [7:0] w_s;
  logic [8:0] w_diff;
  logic [7:0] w_abs;
  logic [8:0] w_sum;
  logic [7:0] w_acc_next;
  logic [7:0] r_acc;
  logic [7:0] r_r_dly;

  assign w_s    = s1s2_mux ? s1 : s2;
  // Borrow in bit 8 means r < s; two's-complement negate the low byte to get |r - s|.
  assign w_diff = {1'b0, r} - {1'b0, w_s};
  assign w_abs  = w_diff[8] ? (~w_diff[7:0] + 8'd1) : w_diff[7:0];
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_abs};

  always_comb begin
    w_acc_next = w_abs;
    if (!new_dist) begin
`ifdef PE_SATURATE_EN
      w_acc_next = w_sum[8] ? 8'hFF : w_sum[7:0];
`else
      w_acc_next = w_sum[7:0];
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= 8'h00;
      r_r_dly <= 8'h00;
    end else begin
      r_acc   <= w_acc_next;
      r_r_dly <= r;
    end
  end

  assign accumulate = r_acc;
  assign r_pipe     = r_r_dly;

endmodule

// File: tb/tb_proccessing_element.sv
// Self-checking bench for proccessing_element: directed vector table, reset corner cases, randomized model check.
module tb_proccessing_element;

  logic       clock;
  logic       reset_n;
  logic [7:0] r, s1, s2;
  logic       s1s2_mux, new_dist;
  logic [7:0] accumulate, r_pipe;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  proccessing_element dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .r          (r),
    .s1         (s1),
    .s2         (s2),
    .s1s2_mux   (s1s2_mux),
    .new_dist   (new_dist),
    .accumulate (accumulate),
    .r_pipe     (r_pipe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] r;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       mux;
    logic       nd;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vec[13];

  // Reference: SAD accumulation computed directly from the arithmetic rules.
  function automatic int model_next(int acc, int ri, int si, bit nd);
    int d, sum;
    d = (ri > si) ? ri - si : si - ri;
    if (nd) return d;
    sum = acc + d;
    if (SAT) return (sum > 255) ? 255 : sum;
    return sum % 256;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic [7:0] ri, input logic [7:0] s1i, input logic [7:0] s2i,
                      input logic mi, input logic ndi);
    r = ri; s1 = s1i; s2 = s2i; s1s2_mux = mi; new_dist = ndi;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int sel;
    r = 0; s1 = 0; s2 = 0; s1s2_mux = 1'b1; new_dist = 1'b1;
    reset_n = 1'b0;
    #2;
    check("reset_acc", accumulate, 8'h00);
    check("reset_pipe", r_pipe, 8'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    vec[0]  = '{8'd8,   8'd0,   8'd8,   1'b1, 1'b1, 8'd8};
    vec[1]  = '{8'd0,   8'd1,   8'd0,   1'b1, 1'b0, 8'd9};
    vec[2]  = '{8'd1,   8'd0,   8'd5,   1'b0, 1'b0, 8'd13};
    vec[3]  = '{8'd2,   8'd0,   8'd7,   1'b0, 1'b0, 8'd18};
    vec[4]  = '{8'd13,  8'd0,   8'd0,   1'b1, 1'b1, 8'd13};
    vec[5]  = '{8'd5,   8'd255, 8'd0,   1'b1, 1'b0, SAT ? 8'd255 : 8'd7};
    vec[6]  = '{8'd0,   8'd200, 8'd0,   1'b1, 1'b0, SAT ? 8'd255 : 8'd207};
    vec[7]  = '{8'd77,  8'd77,  8'd3,   1'b1, 1'b1, 8'd0};
    vec[8]  = '{8'd2,   8'd0,   8'd7,   1'b1, 1'b1, 8'd2};
    vec[9]  = '{8'd2,   8'd0,   8'd7,   1'b0, 1'b1, 8'd5};
    vec[10] = '{8'd255, 8'd0,   8'd9,   1'b1, 1'b1, 8'd255};
    vec[11] = '{8'd0,   8'd1,   8'd255, 1'b0, 1'b0, SAT ? 8'd255 : 8'd254};
    vec[12] = '{8'd128, 8'd128, 8'd0,   1'b1, 1'b0, SAT ? 8'd255 : 8'd254};

    for (int i = 0; i < 13; i++) begin
      step(vec[i].r, vec[i].s1, vec[i].s2, vec[i].mux, vec[i].nd);
      check($sformatf("vec%0d_acc", i), accumulate, vec[i].exp_acc);
      check($sformatf("vec%0d_pipe", i), r_pipe, vec[i].r);
      $display("vec %0d r=%0d s1=%0d s2=%0d mux=%0d nd=%0d acc=%0d", i, vec[i].r, vec[i].s1,
               vec[i].s2, vec[i].mux, vec[i].nd, accumulate);
    end

    // Mid-sum reset: outputs clear without a clock edge, then accumulation restarts from zero.
    step(8'd10, 8'd3, 8'd0, 1'b1, 1'b1);
    step(8'd11, 8'd3, 8'd0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_acc", accumulate, 8'h00);
    check("midreset_pipe", r_pipe, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    step(8'h2A, 8'h20, 8'h00, 1'b1, 1'b0);
    check("post_reset_pipe", r_pipe, 8'h2A);
    check("post_reset_acc", accumulate, 8'd10);
    m_acc = 10;

    for (int n = 0; n < 400; n++) begin
      logic [7:0] rr, a, b;
      logic mm, nd;
      sel = $urandom_range(0, 3);
      rr = (sel == 0) ? 8'(($urandom_range(0, 1)) * 255) : 8'($urandom);
      a  = 8'($urandom);
      b  = (sel == 1) ? rr : 8'($urandom);
      mm = 1'($urandom);
      nd = ($urandom_range(0, 7) == 0);
      step(rr, a, b, mm, nd);
      m_acc = model_next(m_acc, int'(rr), mm ? int'(a) : int'(b), nd);
      check("rand_acc", accumulate, 8'(m_acc));
      check("rand_pipe", r_pipe, rr);
      $display("rand %0d r=%0d s=%0d nd=%0d acc=%0d", n, rr, mm ? a : b, nd, accumulate);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
